// File: rtl/snax_gemmx_ctrl_pkg.sv
// rtl/snax_gemmx_ctrl_pkg.sv - shared types and constants for the GEMMX launch controller
package snax_gemmx_ctrl_pkg;

  localparam int unsigned WordWidth = 32;

  localparam int unsigned IdxK        = 0;
  localparam int unsigned IdxN        = 1;
  localparam int unsigned IdxM        = 2;
  localparam int unsigned IdxSub      = 3;
  localparam int unsigned IdxSimd0    = 4;
  localparam int unsigned IdxSimd3    = 7;
  localparam int unsigned IdxBypass   = 8;
  localparam int unsigned IdxReserved = 9;

  typedef struct packed {
    logic [3:0][WordWidth-1:0] gemm;
    logic [3:0][WordWidth-1:0] simd;
    logic                      bypass;
    logic [WordWidth-1:0]      reserved;
  } job_t;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitBusy = 2'd2,
    StRun      = 2'd3
  } state_e;

  // A job with any zero loop bound does no work and is retired without launching.
  function automatic logic has_zero_dim(input job_t job);
    return (job.gemm[IdxK] == '0) || (job.gemm[IdxN] == '0) || (job.gemm[IdxM] == '0);
  endfunction

endpackage

// File: rtl/snax_gemmx_job_fifo.sv
// rtl/snax_gemmx_job_fifo.sv - synchronous FIFO holding complete job records
module snax_gemmx_job_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full queue refuses a push even when the head leaves in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CntW'(Depth));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snax_gemmx_launch_ctrl.sv
// rtl/snax_gemmx_launch_ctrl.sv - queues CSR job records and launches them on the GEMMX accelerator
module snax_gemmx_launch_ctrl
  import snax_gemmx_ctrl_pkg::*;
#(
  parameter int unsigned RegRWCount   = 10,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned QueueDepth   = 2,
  localparam int unsigned PendW = $clog2(QueueDepth + 2),
  localparam int unsigned CntW  = $clog2(QueueDepth + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_i,
  input  logic                                   csr_reg_set_valid_i,
  output logic                                   csr_reg_set_ready_o,
  output logic [3:0][RegDataWidth-1:0]           gemm_cfg_o,
  output logic                                   gemm_cfg_valid_o,
  input  logic                                   gemm_cfg_ready_i,
  output logic [3:0][RegDataWidth-1:0]           simd_cfg_o,
  output logic                                   simd_cfg_valid_o,
  input  logic                                   simd_cfg_ready_i,
  output logic                                   bypass_simd_o,
  input  logic                                   acc_busy_i,
  output logic [PendW-1:0]                       pending_jobs_o,
  output logic [31:0]                            done_count_o,
  output logic                                   ctrl_busy_o
);

  job_t            in_job;
  job_t            head;
  logic            fifo_pop;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  state_e          state;
  logic            unused_bits;

  always_comb begin
    in_job          = '0;
    in_job.gemm     = csr_reg_set_i[IdxSub:IdxK];
    in_job.simd     = csr_reg_set_i[IdxSimd3:IdxSimd0];
    in_job.bypass   = csr_reg_set_i[IdxBypass][0];
    in_job.reserved = csr_reg_set_i[IdxReserved];
  end

  // Only bit 0 of the bypass word and none of the reserved word affect behaviour.
  assign unused_bits = ^{csr_reg_set_i[IdxBypass][RegDataWidth-1:1], head.reserved};

  snax_gemmx_job_fifo #(
    .Depth (QueueDepth),
    .Width ($bits(job_t))
  ) u_job_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (csr_reg_set_valid_i),
    .push_data (in_job),
    .pop       (fifo_pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_pop            = (state == StIdle) && !fifo_empty;
  assign csr_reg_set_ready_o = !fifo_full;
  assign pending_jobs_o      = PendW'(fifo_count) + PendW'(state != StIdle);
  assign ctrl_busy_o         = (state != StIdle) || !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= StIdle;
      gemm_cfg_o       <= '0;
      simd_cfg_o       <= '0;
      bypass_simd_o    <= 1'b0;
      gemm_cfg_valid_o <= 1'b0;
      simd_cfg_valid_o <= 1'b0;
      done_count_o     <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (!fifo_empty) begin
            gemm_cfg_o    <= head.gemm;
            simd_cfg_o    <= head.simd;
            bypass_simd_o <= head.bypass;
            if (has_zero_dim(head)) begin
              done_count_o <= done_count_o + 32'd1;
            end else begin
              state            <= StIssue;
              gemm_cfg_valid_o <= 1'b1;
              simd_cfg_valid_o <= !head.bypass;
            end
          end
        end
        StIssue: begin
          // Channels are independent; leave once neither has an outstanding config.
          if (gemm_cfg_ready_i) begin
            gemm_cfg_valid_o <= 1'b0;
          end
          if (simd_cfg_ready_i) begin
            simd_cfg_valid_o <= 1'b0;
          end
          if ((!gemm_cfg_valid_o || gemm_cfg_ready_i) &&
              (!simd_cfg_valid_o || simd_cfg_ready_i)) begin
            state <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (acc_busy_i) begin
            state <= StRun;
          end
        end
        StRun: begin
          if (!acc_busy_i) begin
            done_count_o <= done_count_o + 32'd1;
            state        <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snax_gemmx_launch_ctrl.sv
// tb/tb_snax_gemmx_launch_ctrl.sv - directed self-checking bench for snax_gemmx_launch_ctrl
module tb_snax_gemmx_launch_ctrl;

  logic             clk;
  logic             rst_n;
  logic [9:0][31:0] csr_set;
  logic             csr_valid;
  logic             csr_ready;
  logic [3:0][31:0] gemm_cfg;
  logic             gemm_valid;
  logic             gemm_ready;
  logic [3:0][31:0] simd_cfg;
  logic             simd_valid;
  logic             simd_ready;
  logic             bypass;
  logic             busy;
  logic [1:0]       pending;
  logic [31:0]      done_count;
  logic             ctrl_busy;

  int checks = 0;
  int errors = 0;

  snax_gemmx_launch_ctrl dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .csr_reg_set_i       (csr_set),
    .csr_reg_set_valid_i (csr_valid),
    .csr_reg_set_ready_o (csr_ready),
    .gemm_cfg_o          (gemm_cfg),
    .gemm_cfg_valid_o    (gemm_valid),
    .gemm_cfg_ready_i    (gemm_ready),
    .simd_cfg_o          (simd_cfg),
    .simd_cfg_valid_o    (simd_valid),
    .simd_cfg_ready_i    (simd_ready),
    .bypass_simd_o       (bypass),
    .acc_busy_i          (busy),
    .pending_jobs_o      (pending),
    .done_count_o        (done_count),
    .ctrl_busy_o         (ctrl_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [31:0] k, input logic [31:0] n, input logic [31:0] m,
                          input logic [31:0] sub, input logic [31:0] sbase, input logic byp);
    csr_set[0] = k;
    csr_set[1] = n;
    csr_set[2] = m;
    csr_set[3] = sub;
    for (int i = 0; i < 4; i++) csr_set[4+i] = sbase + 32'(i);
    csr_set[8] = {31'd0, byp};
    csr_set[9] = 32'hdead_beef;
    csr_valid  = 1'b1;
    step(1);
    csr_valid  = 1'b0;
  endtask

  task automatic busy_pulse();
    busy = 1'b1;
    step(1);
    busy = 1'b0;
    step(1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pending != 2'd0 || ctrl_busy) && n < 200) begin
      busy = ~busy;
      step(1);
      n++;
    end
    busy = 1'b0;
    check(tag, {63'd0, ctrl_busy}, 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    csr_set    = '0;
    csr_valid  = 1'b0;
    gemm_ready = 1'b0;
    simd_ready = 1'b0;
    busy       = 1'b0;
    step(2);
    check("rst_ready", {63'd0, csr_ready}, 64'd1);
    check("rst_pending", {62'd0, pending}, 64'd0);
    check("rst_cfg", {63'd0, |{gemm_cfg, simd_cfg, bypass, gemm_valid, simd_valid}}, 64'd0);
    rst_n = 1'b1;
    step(1);

    // single job, both readies high
    gemm_ready = 1'b1;
    simd_ready = 1'b1;
    push_job(32'd2, 32'd2, 32'd2, 32'd7, 32'h100, 1'b0);
    check("t1_c1_pending", {62'd0, pending}, 64'd1);
    check("t1_c1_gvalid", {63'd0, gemm_valid}, 64'd0);
    step(1);
    check("t1_c2_gvalid", {63'd0, gemm_valid}, 64'd1);
    check("t1_c2_svalid", {63'd0, simd_valid}, 64'd1);
    check("t1_c2_k", {32'd0, gemm_cfg[0]}, 64'd2);
    check("t1_c2_sub", {32'd0, gemm_cfg[3]}, 64'd7);
    check("t1_c2_simd3", {32'd0, simd_cfg[3]}, 64'h103);
    step(1);
    check("t1_c3_valids", {62'd0, gemm_valid, simd_valid}, 64'd0);
    check("t1_c3_pending", {62'd0, pending}, 64'd1);
    step(2);
    busy = 1'b1;
    step(1);
    check("t1_run_done", {32'd0, done_count}, 64'd0);
    busy = 1'b0;
    step(1);
    check("t1_done", {32'd0, done_count}, 64'd1);
    check("t1_pending", {62'd0, pending}, 64'd0);
    check("t1_ctrl_busy", {63'd0, ctrl_busy}, 64'd0);

    // staggered readies
    gemm_ready = 1'b0;
    simd_ready = 1'b0;
    push_job(32'd3, 32'd4, 32'd5, 32'h11, 32'h200, 1'b0);
    step(1);
    check("t2_c2_valids", {62'd0, gemm_valid, simd_valid}, 64'd3);
    step(1);
    check("t2_c3_valids", {62'd0, gemm_valid, simd_valid}, 64'd3);
    check("t2_c3_m", {32'd0, gemm_cfg[2]}, 64'd5);
    gemm_ready = 1'b1;
    step(1);
    gemm_ready = 1'b0;
    check("t2_c4_valids", {62'd0, gemm_valid, simd_valid}, 64'd1);
    check("t2_c4_simd1", {32'd0, simd_cfg[1]}, 64'h201);
    step(2);
    check("t2_c6_valids", {62'd0, gemm_valid, simd_valid}, 64'd1);
    check("t2_c6_simd1", {32'd0, simd_cfg[1]}, 64'h201);
    check("t2_c6_n", {32'd0, gemm_cfg[1]}, 64'd4);
    simd_ready = 1'b1;
    step(1);
    simd_ready = 1'b0;
    check("t2_c7_valids", {62'd0, gemm_valid, simd_valid}, 64'd0);
    check("t2_c7_busy", {63'd0, ctrl_busy}, 64'd1);
    busy_pulse();
    check("t2_done", {32'd0, done_count}, 64'd2);

    // bypass job, SIMD channel never ready
    gemm_ready = 1'b1;
    push_job(32'd1, 32'd1, 32'd1, 32'd0, 32'h300, 1'b1);
    step(1);
    check("t3_c2_valids", {62'd0, gemm_valid, simd_valid}, 64'd2);
    check("t3_c2_bypass", {63'd0, bypass}, 64'd1);
    step(1);
    check("t3_c3_valids", {62'd0, gemm_valid, simd_valid}, 64'd0);
    busy_pulse();
    check("t3_done", {32'd0, done_count}, 64'd3);
    check("t3_bypass_hold", {63'd0, bypass}, 64'd1);

    // queue full with the accelerator held busy
    simd_ready = 1'b1;
    busy       = 1'b1;
    push_job(32'd10, 32'd1, 32'd1, 32'd0, 32'h400, 1'b0);
    push_job(32'd20, 32'd1, 32'd1, 32'd0, 32'h500, 1'b0);
    push_job(32'd30, 32'd1, 32'd1, 32'd0, 32'h600, 1'b0);
    check("t4_ready_full", {63'd0, csr_ready}, 64'd0);
    check("t4_pending_full", {62'd0, pending}, 64'd3);
    push_job(32'd40, 32'd1, 32'd1, 32'd0, 32'h700, 1'b0);
    check("t4_reject_pending", {62'd0, pending}, 64'd3);
    busy = 1'b0;
    step(1);
    check("t4_done_a", {32'd0, done_count}, 64'd4);
    check("t4_pending_a", {62'd0, pending}, 64'd2);
    step(1);
    check("t4_b_valid", {63'd0, gemm_valid}, 64'd1);
    check("t4_b_k", {32'd0, gemm_cfg[0]}, 64'd20);
    check("t4_b_ready", {63'd0, csr_ready}, 64'd1);
    drain("t4_drain");
    check("t4_done_all", {32'd0, done_count}, 64'd6);

    // zero dimension job followed by a valid job
    push_job(32'd4, 32'd4, 32'd0, 32'd0, 32'h800, 1'b0);
    push_job(32'd5, 32'd6, 32'd7, 32'd0, 32'h900, 1'b0);
    check("t5_drop_valids", {62'd0, gemm_valid, simd_valid}, 64'd0);
    check("t5_drop_done", {32'd0, done_count}, 64'd7);
    check("t5_drop_m", {32'd0, gemm_cfg[2]}, 64'd0);
    step(1);
    check("t5_next_valid", {63'd0, gemm_valid}, 64'd1);
    check("t5_next_k", {32'd0, gemm_cfg[0]}, 64'd5);
    drain("t5_drain");
    check("t5_done", {32'd0, done_count}, 64'd8);

    // reset during RUN with one job queued
    busy = 1'b1;
    push_job(32'd9, 32'd9, 32'd9, 32'd0, 32'ha00, 1'b1);
    push_job(32'd8, 32'd8, 32'd8, 32'd0, 32'hb00, 1'b0);
    step(2);
    check("t6_pre_pending", {62'd0, pending}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pending", {62'd0, pending}, 64'd0);
    check("t6_rst_done", {32'd0, done_count}, 64'd0);
    check("t6_rst_ready", {63'd0, csr_ready}, 64'd1);
    check("t6_rst_outs", {63'd0, |{gemm_cfg, simd_cfg, bypass, gemm_valid, simd_valid, ctrl_busy}}, 64'd0);
    busy = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    check("t6_post_pending", {62'd0, pending}, 64'd0);
    check("t6_post_done", {32'd0, done_count}, 64'd0);
    check("t6_post_idle", {61'd0, ctrl_busy, gemm_valid, simd_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
